// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer for a direct-mapped instruction cache: stalls the front end on a
// fetch miss, streams the line in word by word, then writes tag+valid and releases the stall.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned INDEX_W        = 7,
  parameter int unsigned WORDS_PER_LINE = 2,
  localparam int unsigned OFFSET_W      = $clog2(WORDS_PER_LINE * 4),
  localparam int unsigned TAG_W         = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned WCNT_W        = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic               hit,
  output logic               pc_we,
  output logic               IFID_we,
  output logic               IDEX_we,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic               cw_en,
  output logic [INDEX_W-1:0] cw_index,
  output logic [WCNT_W-1:0]  cw_word,
  output logic [31:0]        cw_data,
  output logic               tag_we,
  output logic [TAG_W-1:0]   tag_data,
  output logic               busy,
  output logic [15:0]        miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_TAGW,
    S_DONE
  } state_e;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic [WCNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]          data_q, data_d;
  logic [15:0]          miss_count_q, miss_count_d;
  logic                 miss;
  logic                 unused_offset;

  // Byte offset within the line is implied by the word counter during refill.
  assign unused_offset = ^fetch_addr[OFFSET_W-1:0];

  assign miss = (state_q == S_IDLE) && fetch_req && !hit;
  assign busy = (state_q != S_IDLE);

  // Gated by reset so the pipeline is frozen for as long as reset is held.
  assign pc_we   = reset && !(miss || busy);
  assign IFID_we = pc_we;
  assign IDEX_we = pc_we;

  assign mem_addr   = {tag_q, index_q, {OFFSET_W{1'b0}}} | (ADDR_W'(cnt_q) << 2);
  assign cw_index   = index_q;
  assign cw_word    = cnt_q;
  assign cw_data    = data_q;
  assign tag_data   = tag_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    index_d      = index_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    miss_count_d = miss_count_q;
    mem_req      = 1'b0;
    cw_en        = 1'b0;
    tag_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (miss) begin
          tag_d   = fetch_addr[ADDR_W-1 -: TAG_W];
          index_d = fetch_addr[OFFSET_W +: INDEX_W];
          cnt_d   = '0;
          if (miss_count_q != '1) miss_count_d = miss_count_q + 16'd1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cw_en = 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = S_TAGW;
        end else begin
          cnt_d   = cnt_q + WCNT_W'(1);
          state_d = S_REQ;
        end
      end
      S_TAGW: begin
        tag_we  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      index_q      <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule
